// File: rtl/seq_stage_controller.sv
// Multi-cycle SEQ Y86-64 sequencer: owns PC, condition codes and status, steps stages with one-hot enables.
// Optional `SEQ_PERF_COUNTERS_EN adds saturating cycle_count / instr_count outputs.
`timescale 1ns/1ps
module seq_stage_controller #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valc,
  input  logic [63:0] valp,
  input  logic [63:0] valm,
  input  logic        condition_cnd,
  input  logic        overflow_flag,
  input  logic        sign_flag,
  input  logic        zero_flag,
  input  logic        instruction_valid,
  input  logic        imem_error,
  input  logic        halt,
  input  logic        dmem_error,
  output logic [63:0] pc_counter,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        execute_en,
  output logic        memory_en,
  output logic        writeback_en,
  output logic        cc_zf,
  output logic        cc_sf,
  output logic        cc_of,
  output logic [1:0]  stat,
  output logic        busy,
  output logic        done
`ifdef SEQ_PERF_COUNTERS_EN
  ,
  output logic [63:0] cycle_count,
  output logic [63:0] instr_count
`endif
);

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_ADR = 2'b10;
  localparam logic [1:0] STAT_INS = 2'b11;

  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_OPQ  = 4'h6;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_STOP
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  fetch_stat;
  logic [63:0] pc_nxt;

  // ifun is carried for the stage blocks; branch resolution arrives already as condition_cnd
  logic unused_ifun;
  assign unused_ifun = ^ifun;

  // fault priority: ADR > INS > HLT
  always_comb begin
    fetch_stat = STAT_AOK;
    if (imem_error)                     fetch_stat = STAT_ADR;
    else if (!instruction_valid)        fetch_stat = STAT_INS;
    else if (halt || icode == I_HALT)   fetch_stat = STAT_HLT;
  end

  always_comb begin
    pc_nxt = valp;
    if (icode == I_CALL)                         pc_nxt = valc;
    else if (icode == I_JXX && condition_cnd)    pc_nxt = valc;
    else if (icode == I_RET)                     pc_nxt = valm;
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state logic; a fault in FETCH or MEMORY skips straight to STOP
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (run || step) state_nxt = S_FETCH;
      S_FETCH:     state_nxt = (fetch_stat != STAT_AOK) ? S_STOP : S_DECODE;
      S_DECODE:    state_nxt = S_EXECUTE;
      S_EXECUTE:   state_nxt = S_MEMORY;
      S_MEMORY:    state_nxt = dmem_error ? S_STOP : S_WRITEBACK;
      S_WRITEBACK: state_nxt = S_PCUPD;
      S_PCUPD:     state_nxt = run ? S_FETCH : S_IDLE;
      S_STOP:      state_nxt = S_STOP;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // output decode
  always_comb begin
    fetch_en     = (state == S_FETCH);
    decode_en    = (state == S_DECODE);
    execute_en   = (state == S_EXECUTE);
    memory_en    = (state == S_MEMORY);
    writeback_en = (state == S_WRITEBACK);
    busy         = (state != S_IDLE) && (state != S_STOP);
  end

  // architectural state
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_counter <= RESET_PC;
      cc_zf      <= 1'b0;
      cc_sf      <= 1'b0;
      cc_of      <= 1'b0;
      stat       <= STAT_AOK;
      done       <= 1'b0;
    end else begin
      done <= (state == S_PCUPD);
      if (state == S_FETCH)                  stat <= fetch_stat;
      if (state == S_MEMORY && dmem_error)   stat <= STAT_ADR;
      if (state == S_EXECUTE && icode == I_OPQ) begin
        cc_zf <= zero_flag;
        cc_sf <= sign_flag;
        cc_of <= overflow_flag;
      end
      if (state == S_PCUPD) pc_counter <= pc_nxt;
    end
  end

`ifdef SEQ_PERF_COUNTERS_EN
  // instr_count steps on the same edge that raises done, so both are visible together
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count <= 64'd0;
      instr_count <= 64'd0;
    end else begin
      if (busy && cycle_count != '1)              cycle_count <= cycle_count + 64'd1;
      if (state == S_PCUPD && instr_count != '1)  instr_count <= instr_count + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_stage_controller.sv
// Directed bench for seq_stage_controller; completed instructions are checked by a scoreboard monitor on done.
`timescale 1ns/1ps
module tb_seq_stage_controller;

  logic        clock = 1'b0;
  logic        reset, run, step;
  logic [3:0]  icode, ifun;
  logic [63:0] valc, valp, valm;
  logic        condition_cnd, overflow_flag, sign_flag, zero_flag;
  logic        instruction_valid, imem_error, halt, dmem_error;
  logic [63:0] pc_counter;
  logic        fetch_en, decode_en, execute_en, memory_en, writeback_en;
  logic        cc_zf, cc_sf, cc_of, busy, done;
  logic [1:0]  stat;
`ifdef SEQ_PERF_COUNTERS_EN
  logic [63:0] cycle_count, instr_count;
`endif

  seq_stage_controller #(.RESET_PC(64'd0)) dut (
    .clock(clock), .reset(reset), .run(run), .step(step),
    .icode(icode), .ifun(ifun), .valc(valc), .valp(valp), .valm(valm),
    .condition_cnd(condition_cnd), .overflow_flag(overflow_flag),
    .sign_flag(sign_flag), .zero_flag(zero_flag),
    .instruction_valid(instruction_valid), .imem_error(imem_error),
    .halt(halt), .dmem_error(dmem_error), .pc_counter(pc_counter),
    .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
    .memory_en(memory_en), .writeback_en(writeback_en),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of), .stat(stat),
    .busy(busy), .done(done)
`ifdef SEQ_PERF_COUNTERS_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { logic [63:0] pc; logic [2:0] cc; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  logic [4:0] en;
  assign en = {fetch_en, decode_en, execute_en, memory_en, writeback_en};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] pc, input logic [2:0] cc);
    exp_t e;
    e.pc = pc; e.cc = cc;
    sb.push_back(e);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!done && n < maxc);
    if (!done) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no_done expected=done_within_%0d", maxc);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // scoreboard monitor: every done pulse must match the oldest expected entry
  always @(negedge clock) begin : mon
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done actual=done_pc_%0h expected=no_done", pc_counter);
      end else begin
        e = sb.pop_front();
        chk("done_pc", pc_counter, e.pc);
        chk("done_cc", {cc_zf, cc_sf, cc_of}, e.cc);
        chk("done_stat", stat, 2'b00);
      end
    end
  end

  initial begin : stim
    logic saw;
    reset = 1'b1; run = 0; step = 0; icode = 0; ifun = 0; valc = 0; valp = 0; valm = 0;
    condition_cnd = 0; overflow_flag = 0; sign_flag = 0; zero_flag = 0;
    instruction_valid = 1; imem_error = 0; halt = 0; dmem_error = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_pc", pc_counter, 64'd0);
    chk("rst_en", en, 5'b0);
    chk("rst_cc", {cc_zf, cc_sf, cc_of}, 3'b0);
    chk("rst_stat", stat, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    // single step of irmovq; a stray step during DECODE must be ignored
    icode = 4'h3; valp = 64'd10;
    push(64'd10, 3'b000);
    pulse_step();
    for (int k = 0; k < 5; k++) begin
      chk("en_walk", en, 5'b10000 >> k);
      step = (k == 1);
      @(negedge clock);
    end
    step = 1'b0;
    chk("pcupd_en", en, 5'b0);
    chk("pcupd_busy", busy, 1'b1);
    chk("pcupd_pc_old", pc_counter, 64'd0);
    @(negedge clock);
    chk("c6_done", done, 1'b1);
    chk("c6_idle", busy, 1'b0);
    @(negedge clock);
    chk("step_ignored_busy", busy, 1'b0);
    chk("done_one_cycle", done, 1'b0);

    // run: OPq sets ZF, then taken jXX; CC held across the jump
    icode = 4'h6; valp = 64'd12; zero_flag = 1'b1;
    push(64'd12, 3'b100);
    run = 1'b1;
    wait_done(20);
    chk("no_bubble", fetch_en, 1'b1);
    icode = 4'h7; condition_cnd = 1'b1; valc = 64'h40; valp = 64'd21; zero_flag = 1'b0;
    push(64'h40, 3'b100);
    @(negedge clock);
    run = 1'b0;
    wait_done(20);
    chk("run_drop_idle", busy, 1'b0);

    // call then ret
    condition_cnd = 1'b0;
    icode = 4'h8; valc = 64'h100; valp = 64'h49;
    push(64'h100, 3'b100);
    pulse_step();
    wait_done(20);
    icode = 4'h9; valm = 64'h22; valp = 64'h101;
    push(64'h22, 3'b100);
    pulse_step();
    wait_done(20);

    // move to 0x30, then halt there
    icode = 4'h8; valc = 64'h30; valp = 64'h2b;
    push(64'h30, 3'b100);
    pulse_step();
    wait_done(20);
    icode = 4'h0; halt = 1'b1; valp = 64'h31;
    pulse_step();
    @(negedge clock);
    chk("hlt_stat", stat, 2'b01);
    chk("hlt_busy", busy, 1'b0);
    chk("hlt_en", en, 5'b0);
    run = 1'b1; step = 1'b1;
    repeat (8) @(negedge clock);
    run = 1'b0; step = 1'b0;
    chk("stop_stat", stat, 2'b01);
    chk("stop_pc", pc_counter, 64'h30);
    chk("stop_busy", busy, 1'b0);
    halt = 1'b0;

    // fault priority and dmem fault
    do_reset();
    chk("rst_stat_clear", stat, 2'b00);
    icode = 4'h3; imem_error = 1'b1; instruction_valid = 1'b0;
    pulse_step();
    @(negedge clock);
    chk("adr_over_ins", stat, 2'b10);
    do_reset();
    imem_error = 1'b0; halt = 1'b1;
    pulse_step();
    @(negedge clock);
    chk("ins_over_hlt", stat, 2'b11);
    do_reset();
    halt = 1'b0; instruction_valid = 1'b1; icode = 4'h5; dmem_error = 1'b1; valp = 64'd10;
    pulse_step();
    saw = 1'b0;
    repeat (8) begin
      saw |= writeback_en;
      @(negedge clock);
    end
    chk("dmem_no_wb", saw, 1'b0);
    chk("dmem_stat", stat, 2'b10);
    chk("dmem_pc", pc_counter, 64'd0);
    dmem_error = 1'b0;

    // reset during EXECUTE of OPq aborts the CC write
    do_reset();
    icode = 4'h6; zero_flag = 1'b1; sign_flag = 1'b1; overflow_flag = 1'b1; valp = 64'd2;
    pulse_step();
    begin : find_ex
      int n = 0;
      while (!execute_en && n < 10) begin @(negedge clock); n++; end
    end
    chk("reached_execute", execute_en, 1'b1);
    do_reset();
    chk("abort_cc", {cc_zf, cc_sf, cc_of}, 3'b000);
    chk("abort_pc", pc_counter, 64'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_en", en, 5'b0);
`ifdef SEQ_PERF_COUNTERS_EN
    chk("perf_cyc_rst", cycle_count, 64'd0);
    chk("perf_ins_rst", instr_count, 64'd0);
`endif
    icode = 4'h3; valp = 64'd10; zero_flag = 0; sign_flag = 0; overflow_flag = 0;
    push(64'd10, 3'b000);
    pulse_step();
    wait_done(20);
`ifdef SEQ_PERF_COUNTERS_EN
    chk("perf_cyc_one", cycle_count, 64'd6);
    chk("perf_ins_one", instr_count, 64'd1);
`endif
    @(negedge clock);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
